// File: rtl/alu_pc_datapath.sv
// alu_pc_datapath: registered 8-bit ALU with C/V/Z/N flags plus 16-bit program counter
// Ports:
//   clk, rst (async, active-low)
//   alu_a, alu_b, alu_mode, carry_in -> alu_out, carry_out, overflow, zero, sign (latency 1)
//   pc_ld, pc_inc, pc_in             -> pc_out (load beats increment)
module alu_pc_datapath #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alu_a,
    input  logic [7:0]  alu_b,
    input  logic [4:0]  alu_mode,
    input  logic        carry_in,
    output logic [7:0]  alu_out,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero,
    output logic        sign,
    input  logic        pc_ld,
    input  logic        pc_inc,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out
);
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_EOR   = 5'd4;
    localparam logic [4:0] ALU_ASL   = 5'd5;
    localparam logic [4:0] ALU_LSR   = 5'd6;
    localparam logic [4:0] ALU_ROL   = 5'd7;
    localparam logic [4:0] ALU_ROR   = 5'd8;
    localparam logic [4:0] ALU_INC   = 5'd9;
    localparam logic [4:0] ALU_DEC   = 5'd10;
    localparam logic [4:0] ALU_CMP   = 5'd11;
    localparam logic [4:0] ALU_PASSB = 5'd12;
    localparam logic [4:0] ALU_BIT   = 5'd13;

    logic [8:0] add_sum, sub_sum, cmp_sum;
    logic       add_v, sub_v;
    logic [7:0] res;
    logic       c_nxt, v_nxt, n_nxt;

    assign add_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, carry_in};
    assign sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, carry_in};
    // CMP forces the carry-in so C reads as unsigned a >= b
    assign cmp_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
    assign add_v   = (alu_a[7] == alu_b[7]) && (add_sum[7] != alu_a[7]);
    assign sub_v   = (alu_a[7] != alu_b[7]) && (sub_sum[7] != alu_a[7]);

    // Reserved codes fall through to the ADD defaults
    always_comb begin
        res   = add_sum[7:0];
        c_nxt = add_sum[8];
        v_nxt = add_v;
        case (alu_mode)
            ALU_SUB:   begin res = sub_sum[7:0];          c_nxt = sub_sum[8]; v_nxt = sub_v; end
            ALU_AND:   begin res = alu_a & alu_b;         c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_OR:    begin res = alu_a | alu_b;         c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_EOR:   begin res = alu_a ^ alu_b;         c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_ASL:   begin res = {alu_a[6:0], 1'b0};    c_nxt = alu_a[7];   v_nxt = 1'b0;  end
            ALU_LSR:   begin res = {1'b0, alu_a[7:1]};    c_nxt = alu_a[0];   v_nxt = 1'b0;  end
            ALU_ROL:   begin res = {alu_a[6:0], carry_in}; c_nxt = alu_a[7];  v_nxt = 1'b0;  end
            ALU_ROR:   begin res = {carry_in, alu_a[7:1]}; c_nxt = alu_a[0];  v_nxt = 1'b0;  end
            ALU_INC:   begin res = alu_a + 8'd1;          c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_DEC:   begin res = alu_a - 8'd1;          c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_CMP:   begin res = cmp_sum[7:0];          c_nxt = cmp_sum[8]; v_nxt = 1'b0;  end
            ALU_PASSB: begin res = alu_b;                 c_nxt = carry_in;   v_nxt = 1'b0;  end
            ALU_BIT:   begin res = alu_a & alu_b;         c_nxt = carry_in;   v_nxt = alu_b[6]; end
            default:   ;
        endcase
        n_nxt = (alu_mode == ALU_BIT) ? alu_b[7] : res[7];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out   <= 8'h00;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            pc_out    <= PC_RESET;
        end else begin
            alu_out   <= res;
            carry_out <= c_nxt;
            overflow  <= v_nxt;
            zero      <= (res == 8'h00);
            sign      <= n_nxt;
            pc_out    <= pc_ld ? pc_in : pc_inc ? pc_out + 16'd1 : pc_out;
        end
    end
endmodule

// File: tb/tb_alu_pc_datapath.sv
// tb_alu_pc_datapath: directed and random checks of the ALU/PC datapath against an arithmetic model
module tb_alu_pc_datapath;
    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_mode;
    logic        carry_in;
    logic [7:0]  alu_out;
    logic        carry_out, overflow, zero, sign;
    logic        pc_ld, pc_inc;
    logic [15:0] pc_in, pc_out;

    int checks = 0;
    int errors = 0;
    int pc_model = 0;

    alu_pc_datapath dut (
        .clk(clk), .rst(rst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .carry_in(carry_in),
        .alu_out(alu_out), .carry_out(carry_out), .overflow(overflow), .zero(zero), .sign(sign),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_in(pc_in), .pc_out(pc_out)
    );

    always #5 if (clk_run) clk = ~clk;

    // Returns {r[7:0], C, V, Z, N} from plain integer arithmetic
    function automatic logic [11:0] model(int m, int a, int b, int cin);
        int r, c, v, n, s, sv, sa, sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = cin;
        v = 0;
        case (m)
            1:  begin s = a + (255 - b) + cin; r = s % 256; c = int'(s > 255);
                      sv = sa - sb - 1 + cin; v = int'(sv < -128 || sv > 127); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  begin r = (a * 2) % 256; c = int'(a >= 128); end
            6:  begin r = a / 2; c = a % 2; end
            7:  begin r = (a * 2 + cin) % 256; c = int'(a >= 128); end
            8:  begin r = a / 2 + cin * 128; c = a % 2; end
            9:  r = (a + 1) % 256;
            10: r = (a + 255) % 256;
            11: begin r = (a - b + 256) % 256; c = int'(a >= b); end
            12: r = b;
            13: begin r = a & b; v = (b / 64) % 2; end
            default: begin s = a + b + cin; r = s % 256; c = int'(s > 255);
                           sv = sa + sb + cin; v = int'(sv < -128 || sv > 127); end
        endcase
        n = (m == 13) ? int'(b >= 128) : int'(r >= 128);
        return {r[7:0], c[0], v[0], r == 0, n[0]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, int m, int a, int b, int cin, int ld, int inc, int pin);
        alu_mode = m[4:0];
        alu_a = a[7:0];
        alu_b = b[7:0];
        carry_in = cin[0];
        pc_ld = ld[0];
        pc_inc = inc[0];
        pc_in = pin[15:0];
        @(posedge clk);
        #1;
        pc_model = ld ? pin : inc ? (pc_model + 1) % 65536 : pc_model;
        check({tag, "_alu"}, {20'h0, alu_out, carry_out, overflow, zero, sign}, {20'h0, model(m, a, b, cin)});
        check({tag, "_pc"}, {16'h0, pc_out}, pc_model);
    endtask

    task automatic check_reset(string tag);
        check(tag, {alu_out, carry_out, overflow, zero, sign, pc_out}, 28'h0);
    endtask

    initial begin
        rst = 1'b1;
        {alu_a, alu_b, alu_mode, carry_in, pc_ld, pc_inc, pc_in} = '0;
        #2 rst = 1'b0;
        #1 check_reset("reset_no_clock");
        #3 rst = 1'b1;
        clk_run = 1'b1;
        step("add_50_50", 0, 'h50, 'h50, 0, 0, 0, 0);
        step("add_ff_01", 0, 'hFF, 'h01, 0, 0, 0, 0);
        step("sub_50_f0", 1, 'h50, 'hF0, 1, 0, 0, 0);
        step("cmp_eq", 11, 'h10, 'h10, 0, 0, 0, 0);
        step("cmp_lt", 11, 'h0F, 'h10, 1, 0, 0, 0);
        step("rol_80", 7, 'h80, 0, 1, 0, 0, 0);
        step("ror_01", 8, 'h01, 0, 0, 0, 0, 0);
        step("lsr_81", 6, 'h81, 0, 0, 0, 0, 0);
        step("bit_0f_c0", 13, 'h0F, 'hC0, 0, 0, 0, 0);
        step("eor_ff_0f", 4, 'hFF, 'h0F, 0, 0, 0, 0);
        step("rsv31", 31, 'h01, 'h02, 1, 0, 0, 0);
        step("inc_ff", 9, 'hFF, 0, 1, 0, 0, 0);
        step("dec_00", 10, 'h00, 0, 0, 0, 0, 0);
        step("pc_load", 12, 0, 'h33, 0, 1, 0, 'hFFFE);
        step("pc_inc1", 5, 'hC1, 0, 0, 0, 1, 0);
        step("pc_inc_wrap", 2, 'hF0, 'h3C, 1, 0, 1, 0);
        step("pc_ld_inc", 3, 'h00, 'h00, 0, 1, 1, 'h1234);
        step("pc_hold1", 0, 0, 0, 0, 0, 0, 'hAAAA);
        step("pc_hold2", 1, 'h80, 'h01, 1, 0, 0, 'h5555);
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(31), $urandom_range(255), $urandom_range(255),
                 $urandom_range(1), int'($urandom_range(7) == 0), $urandom_range(1), $urandom_range(65535));
        alu_mode = 5'd0; alu_a = 8'h7F; alu_b = 8'h01; pc_inc = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset("reset_async_midrun");
        @(posedge clk);
        #1 check_reset("reset_held");
        rst = 1'b1;
        pc_model = 0;
        step("after_reset", 0, 'h7F, 'h01, 0, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pc_datapath.md
# alu_pc_datapath

8-bit ALU plus 16-bit program counter register for the 6502-style CPU core. The ALU takes two operands, a 5-bit operation code and a carry input, and produces a registered result with C/V/Z/N flag outputs. The PC register holds the 16-bit fetch address and supports parallel load and increment. The CPU controller drives operands and controls; this block contains no decode or state machine.

## Interface
- PC_RESET, 16'h0000, value loaded into pc_out on reset
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- alu_a  input  8  operand A (normally accumulator)
- alu_b  input  8  operand B (normally memory data)
- alu_mode  input  5  operation select, encoding below
- carry_in  input  1  carry / no-borrow / rotate-in bit
- alu_out  output  8  registered result
- carry_out  output  1  registered C flag
- overflow  output  1  registered V flag
- zero  output  1  registered Z flag
- sign  output  1  registered N flag
- pc_ld  input  1  load pc_in into PC
- pc_inc  input  1  increment PC
- pc_in  input  16  parallel load value
- pc_out  output  16  current PC

## Operation
- r = 8-bit result; Z = (r == 0); N = r[7] unless stated; V = 0 unless stated; C = carry_in unless stated.
- 0 ALU_ADD: {C,r} = a + b + carry_in (9-bit); V = (a[7]==b[7]) && (r[7]!=a[7]).
- 1 ALU_SUB: {C,r} = a + ~b + carry_in; C=1 means no borrow; V = (a[7]!=b[7]) && (r[7]!=a[7]).
- 2 ALU_AND: r = a & b. 3 ALU_OR: r = a | b. 4 ALU_EOR: r = a ^ b.
- 5 ALU_ASL: r = {a[6:0],0}, C = a[7]. 6 ALU_LSR: r = {0,a[7:1]}, C = a[0].
- 7 ALU_ROL: r = {a[6:0],carry_in}, C = a[7]. 8 ALU_ROR: r = {carry_in,a[7:1]}, C = a[0].
- 9 ALU_INC: r = a + 1, wraps FF->00. 10 ALU_DEC: r = a - 1, wraps 00->FF.
- 11 ALU_CMP: r = a - b (a + ~b + 1), C = (a >= b) unsigned; carry_in ignored.
- 12 ALU_PASSB: r = b.
- 13 ALU_BIT: r = a & b, Z from r, N = b[7], V = b[6].
- 14-31 reserved: behave exactly as ALU_ADD.
- Binary arithmetic only; no decimal mode.
- PC: pc_ld has priority: PC <= pc_in; else pc_inc: PC <= PC + 1 (FFFF wraps to 0000); else hold.
- pc_ld and pc_inc together: load wins, no increment.
- CPU decides which flags to commit to its status register; this block computes all flags every cycle.

## Timing
- ALU: inputs sampled at rising edge; alu_out and all four flags valid one cycle later (latency 1), updated every cycle, no enable.
- PC: pc_out updates at the rising edge where pc_ld or pc_inc is sampled high; latency 1.
- Reset (rst low): immediately, independent of clk: alu_out=8'h00, carry_out=0, overflow=0, zero=0, sign=0, pc_out=PC_RESET.
- Reset asserted mid-operation discards pending results; first edge after rst deasserts computes from the inputs present then.
- No combinational path from any input to any output.

## Test plan
- Reset: rst low with clk stopped -> alu_out=00, all flags 0, pc_out=0000 without a clock edge.
- ADD: a=50, b=50, cin=0 -> r=A0, C=0, V=1, N=1, Z=0; a=FF, b=01, cin=0 -> r=00, C=1, Z=1, V=0.
- SUB/CMP: SUB a=50, b=F0, cin=1 -> r=60, C=0, V=0; CMP a=10, b=10 -> r=00, C=1, Z=1; CMP a=0F, b=10 -> C=0, N=1.
- Shifts/rotates: ROL a=80, cin=1 -> r=01, C=1; ROR a=01, cin=0 -> r=00, C=1, Z=1; LSR a=81 -> r=40, C=1.
- BIT/logic: BIT a=0F, b=C0 -> r=00, Z=1, N=1, V=1; EOR a=FF, b=0F -> r=F0, N=1; reserved mode 31 with a=01, b=02, cin=1 -> r=04.
- PC: load FFFE, then two inc cycles -> FFFF, 0000; pc_ld=1 and pc_inc=1 with pc_in=1234 -> 1234; idle cycles -> hold.
